// File: rtl/reorder_buffer_mp_pkg.sv
// Shared ROB constants: default tag width and depth, the "no tag" value, and a tag range helper.
package reorder_buffer_mp_pkg;

  localparam int ROB_TAG_W = 4;
  localparam int ROB_DEPTH = 15;
  localparam int TAG_NONE  = 0;

  // Valid tags are 1..depth; TAG_NONE and anything beyond the array never address a slot.
  function automatic logic tag_in_range(input int tag, input int depth);
    return (tag != TAG_NONE) && (tag <= depth);
  endfunction

endpackage

// File: rtl/rob_wb_select.sv
// Per-slot write-back select: finds the lowest-index channel whose tag matches this slot.
// Purely combinational; the owner decides whether the hit is accepted.
module rob_wb_select #(
  parameter int TAG_W  = 4,
  parameter int XLEN   = 32,
  parameter int NUM_WB = 2
) (
  input  logic [TAG_W-1:0]        slot_tag_i,
  input  logic [NUM_WB-1:0]       wb_valid_i,
  input  logic [NUM_WB*TAG_W-1:0] wb_tag_i,
  input  logic [NUM_WB*XLEN-1:0]  wb_val_i,
  input  logic [NUM_WB-1:0]       wb_redirect_i,
  input  logic [NUM_WB*XLEN-1:0]  wb_target_i,
  output logic                    hit_o,
  output logic [XLEN-1:0]         val_o,
  output logic                    redirect_o,
  output logic [XLEN-1:0]         target_o
);

  always_comb begin
    hit_o      = 1'b0;
    val_o      = '0;
    redirect_o = 1'b0;
    target_o   = '0;
    // Scan high to low so the lowest matching channel is the one left standing.
    for (int c = NUM_WB - 1; c >= 0; c--) begin
      if (wb_valid_i[c] && (wb_tag_i[c*TAG_W +: TAG_W] == slot_tag_i)) begin
        hit_o      = 1'b1;
        val_o      = wb_val_i[c*XLEN +: XLEN];
        redirect_o = wb_redirect_i[c];
        target_o   = wb_target_i[c*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/reorder_buffer_mp.sv
// In-order-commit reorder buffer with NUM_WB out-of-order write-back channels and mispredict self-flush.
// Optional ROB_QUERY_EN adds two combinational operand-lookup ports.
module reorder_buffer_mp
  import reorder_buffer_mp_pkg::*;
#(
  parameter int DEPTH  = ROB_DEPTH,
  parameter int TAG_W  = ROB_TAG_W,
  parameter int XLEN   = 32,
  parameter int NUM_WB = 2
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    rdy_in,
  input  logic                    flush_in,
  input  logic                    push_valid_in,
  output logic                    push_ready_out,
  input  logic [4:0]              push_rd_idx_in,
  input  logic [XLEN-1:0]         push_pc_in,
  output logic [TAG_W-1:0]        push_tag_out,
  input  logic [NUM_WB-1:0]       wb_valid_in,
  input  logic [NUM_WB*TAG_W-1:0] wb_tag_in,
  input  logic [NUM_WB*XLEN-1:0]  wb_val_in,
  input  logic [NUM_WB-1:0]       wb_redirect_in,
  input  logic [NUM_WB*XLEN-1:0]  wb_target_in,
  output logic                    commit_valid_out,
  input  logic                    commit_ready_in,
  output logic [TAG_W-1:0]        commit_tag_out,
  output logic [4:0]              commit_rd_idx_out,
  output logic [XLEN-1:0]         commit_val_out,
  output logic [XLEN-1:0]         commit_pc_out,
  output logic                    flush_out,
  output logic [XLEN-1:0]         flush_target_out,
`ifdef ROB_QUERY_EN
  input  logic [2*TAG_W-1:0]      qry_tag_in,
  output logic [1:0]              qry_ready_out,
  output logic [2*XLEN-1:0]       qry_val_out,
`endif
  output logic [TAG_W:0]          count_out
);

  if (DEPTH < 2 || DEPTH > (2**TAG_W) - 1) begin : g_bad_depth
    $error("reorder_buffer_mp: DEPTH must lie in 2..2**TAG_W-1");
  end

  localparam logic [TAG_W-1:0] ONE   = TAG_W'(1);
  localparam logic [TAG_W-1:0] LAST  = TAG_W'(DEPTH - 1);
  localparam logic [TAG_W:0]   CONE  = (TAG_W+1)'(1);
  localparam logic [TAG_W:0]   FULL  = (TAG_W+1)'(DEPTH);

  logic [DEPTH-1:0] valid_q, done_q, redir_q;
  logic [4:0]       rd_q  [DEPTH];
  logic [XLEN-1:0]  pc_q  [DEPTH];
  logic [XLEN-1:0]  val_q [DEPTH];
  logic [XLEN-1:0]  tgt_q [DEPTH];
  logic [TAG_W-1:0] head_q, head_d, rear_q, rear_d;
  logic [TAG_W:0]   count_q, count_d;
  logic             flush_q;
  logic [XLEN-1:0]  flush_tgt_q;

  logic [DEPTH-1:0] hit, hit_redir;
  logic [XLEN-1:0]  hit_val [DEPTH];
  logic [XLEN-1:0]  hit_tgt [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    rob_wb_select #(.TAG_W(TAG_W), .XLEN(XLEN), .NUM_WB(NUM_WB)) u_sel (
      .slot_tag_i   (TAG_W'(i + 1)),
      .wb_valid_i   (wb_valid_in),
      .wb_tag_i     (wb_tag_in),
      .wb_val_i     (wb_val_in),
      .wb_redirect_i(wb_redirect_in),
      .wb_target_i  (wb_target_in),
      .hit_o        (hit[i]),
      .val_o        (hit_val[i]),
      .redirect_o   (hit_redir[i]),
      .target_o     (hit_tgt[i])
    );
  end

  assign push_ready_out    = count_q < FULL;
  assign push_tag_out      = rear_q + ONE;
  assign commit_valid_out  = valid_q[head_q] & done_q[head_q];
  assign commit_tag_out    = head_q + ONE;
  assign commit_rd_idx_out = rd_q[head_q];
  assign commit_val_out    = val_q[head_q];
  assign commit_pc_out     = pc_q[head_q];
  assign flush_out         = flush_q;
  assign flush_target_out  = flush_tgt_q;
  assign count_out         = count_q;

  logic push_fire, commit_fire, redir_fire, clear_all;
  assign push_fire   = rdy_in & push_valid_in & push_ready_out;
  assign commit_fire = rdy_in & commit_valid_out & commit_ready_in;
  // An external flush wins over a same-cycle mispredict commit and suppresses flush_out.
  assign redir_fire  = commit_fire & redir_q[head_q] & ~flush_in;
  assign clear_all   = rdy_in & (flush_in | redir_fire);

  always_comb begin
    head_d  = head_q;
    rear_d  = rear_q;
    count_d = count_q;
    if (clear_all) begin
      head_d  = '0;
      rear_d  = '0;
      count_d = '0;
    end else begin
      if (push_fire)   rear_d = (rear_q == LAST) ? '0 : rear_q + ONE;
      if (commit_fire) head_d = (head_q == LAST) ? '0 : head_q + ONE;
      if (push_fire && !commit_fire)      count_d = count_q + CONE;
      else if (commit_fire && !push_fire) count_d = count_q - CONE;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_q     <= '0;
      done_q      <= '0;
      redir_q     <= '0;
      head_q      <= '0;
      rear_q      <= '0;
      count_q     <= '0;
      flush_q     <= 1'b0;
      flush_tgt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]  <= '0;
        pc_q[i]  <= '0;
        val_q[i] <= '0;
        tgt_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      rear_q  <= rear_d;
      count_q <= count_d;
      flush_q <= redir_fire;
      if (redir_fire) flush_tgt_q <= tgt_q[head_q];
      if (clear_all) begin
        valid_q <= '0;
        done_q  <= '0;
        redir_q <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          rd_q[i]  <= '0;
          pc_q[i]  <= '0;
          val_q[i] <= '0;
          tgt_q[i] <= '0;
        end
      end else if (rdy_in) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (hit[i] && valid_q[i] && !done_q[i]) begin
            done_q[i]  <= 1'b1;
            val_q[i]   <= hit_val[i];
            redir_q[i] <= hit_redir[i];
            tgt_q[i]   <= hit_tgt[i];
          end
        end
        // The rear slot is always empty when a push fires, so it never collides with a write-back.
        if (push_fire) begin
          valid_q[rear_q] <= 1'b1;
          done_q[rear_q]  <= 1'b0;
          redir_q[rear_q] <= 1'b0;
          rd_q[rear_q]    <= push_rd_idx_in;
          pc_q[rear_q]    <= push_pc_in;
          val_q[rear_q]   <= '0;
          tgt_q[rear_q]   <= '0;
        end
        if (commit_fire) begin
          valid_q[head_q] <= 1'b0;
          done_q[head_q]  <= 1'b0;
          redir_q[head_q] <= 1'b0;
          rd_q[head_q]    <= '0;
          pc_q[head_q]    <= '0;
          val_q[head_q]   <= '0;
          tgt_q[head_q]   <= '0;
        end
      end
    end
  end

`ifdef ROB_QUERY_EN
  for (genvar q = 0; q < 2; q++) begin : g_qry
    logic [TAG_W-1:0] qtag, qidx;
    logic             qok;
    assign qtag = qry_tag_in[q*TAG_W +: TAG_W];
    assign qok  = tag_in_range(int'(qtag), DEPTH);
    assign qidx = qok ? qtag - ONE : '0;
    assign qry_ready_out[q]          = qok & valid_q[qidx] & done_q[qidx];
    assign qry_val_out[q*XLEN +: XLEN] = qry_ready_out[q] ? val_q[qidx] : '0;
  end
`endif

endmodule
